// File: rtl/hqm_AW_pkg.sv
// Shared types and helpers for the in-order checker: FSM state encoding,
// mismatch counter width and the AW_logb2 sizing function.
package hqm_AW_pkg;

    localparam int unsigned MISMATCH_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FAIL = 2'd2
    } chk_state_t;

    // floor(log2(value)); returns 0 for value <= 1
    function automatic int unsigned AW_logb2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 1; i < 32; i++) begin
            if (value >= (32'd1 << i)) begin
                result = i;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/hqm_assertion_inorder_store.sv
// Expected-item store for the in-order checker: DEPTH-entry circular buffer
// with write/read pointers and an occupancy count. Head is read combinationally
// so the checker can judge the entry in the same cycle act_v arrives.
module hqm_assertion_inorder_store
    import hqm_AW_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 3
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [DWIDTH-1:0] head_data,
    output logic [AWIDTH:0]   occ
);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AWIDTH-1:0] wp_q;
    logic [AWIDTH-1:0] rp_q;
    logic [AWIDTH:0]   occ_q;
    logic [AWIDTH:0]   occ_d;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Each entry captures push_data when the write pointer selects it
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_q[gi] <= '0;
                end else if (push && (wp_q == AWIDTH'(gi))) begin
                    mem_q[gi] <= push_data;
                end
            end
        end
    endgenerate

    // Occupancy follows accepted pushes and pops; flush empties in one cycle
    always_comb begin
        occ_d = occ_q + {{AWIDTH{1'b0}}, push} - {{AWIDTH{1'b0}}, pop};
        if (flush) begin
            occ_d = '0;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
            if (flush) begin
                wp_q <= '0;
                rp_q <= '0;
            end else begin
                if (push) begin
                    wp_q <= wp_q + 1'b1;
                end
                if (pop) begin
                    rp_q <= rp_q + 1'b1;
                end
            end
        end
    end

    assign head_data = mem_q[rp_q];
    assign occ       = occ_q;

endmodule

// File: rtl/hqm_assertion_inorder_chk.sv
// In-order scoreboard checker: expected items from an upstream stage are
// queued and compared, in order and under cmp_mask, against actual items
// from a downstream stage. Errors are reported as registered one-cycle
// pulses plus a sticky flag, a saturating mismatch count and the operands
// of the first mismatch.
// Optional: define HQM_ASSERTION_INORDER_CHK_REPORT_EN to get a simulation
// $error message on every error pulse.
module hqm_assertion_inorder_chk
    import hqm_AW_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DWIDTH = 16,
    parameter int AWIDTH = AW_logb2(DEPTH - 1) + 1
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      exp_v,
    input  logic [DWIDTH-1:0]         exp_data,
    input  logic                      act_v,
    input  logic [DWIDTH-1:0]         act_data,
    input  logic [DWIDTH-1:0]         cmp_mask,
    output logic [AWIDTH:0]           occ,
    output logic                      empty,
    output logic                      full,
    output logic                      err_mismatch,
    output logic                      err_underflow,
    output logic                      err_overflow,
    output logic                      err_sticky,
    output logic [MISMATCH_CNT_W-1:0] mismatch_cnt,
    output logic [DWIDTH-1:0]         cap_exp,
    output logic [DWIDTH-1:0]         cap_act
);

    chk_state_t state_q;
    chk_state_t state_d;

    logic [AWIDTH:0]   occ_w;
    logic [DWIDTH-1:0] head_data;
    logic              empty_w;
    logic              full_w;
    logic              active;
    logic              start;

    logic              push;
    logic              pop;
    logic              cmp_en;
    logic [DWIDTH-1:0] cmp_ref;
    logic              mismatch;
    logic              underflow;
    logic              overflow;
    logic              any_err;

    logic                      err_mismatch_q;
    logic                      err_underflow_q;
    logic                      err_overflow_q;
    logic                      err_sticky_q;
    logic                      err_sticky_d;
    logic [MISMATCH_CNT_W-1:0] mismatch_cnt_q;
    logic [MISMATCH_CNT_W-1:0] mismatch_cnt_d;
    logic [DWIDTH-1:0]         cap_exp_q;
    logic [DWIDTH-1:0]         cap_act_q;

    // Items are only processed once the FSM has left IDLE and enable is still high;
    // any other cycle flushes the store so pending items vanish without underflow.
    assign active  = (state_q != IDLE) && enable;
    assign start   = (state_q == IDLE) && enable;
    assign empty_w = (occ_w == '0);
    assign full_w  = (occ_w == (AWIDTH + 1)'(DEPTH));

    hqm_assertion_inorder_store #(
        .DEPTH  (DEPTH),
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (exp_data),
        .pop       (pop),
        .flush     (!active),
        .head_data (head_data),
        .occ       (occ_w)
    );

    // Decide push/pop/compare for this cycle, including the empty bypass and full corner cases
    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        cmp_en    = 1'b0;
        cmp_ref   = head_data;
        underflow = 1'b0;
        overflow  = 1'b0;
        if (active) begin
            if (exp_v && act_v && empty_w) begin
                // nothing queued: the expected item is compared straight through
                cmp_en  = 1'b1;
                cmp_ref = exp_data;
            end else begin
                if (act_v) begin
                    if (empty_w) begin
                        underflow = 1'b1;
                    end else begin
                        pop    = 1'b1;
                        cmp_en = 1'b1;
                    end
                end
                if (exp_v) begin
                    // when full, a simultaneous pop frees the slot being written
                    if (full_w && !act_v) begin
                        overflow = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
        end
        mismatch = cmp_en && (((act_data ^ cmp_ref) & cmp_mask) != '0);
        any_err  = mismatch || underflow || overflow;
    end

    // FSM next state: FAIL is only left by dropping enable
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = IDLE;
                     else if (any_err) state_d = FAIL;
            FAIL:    if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Statistics next values: cleared when checking (re)starts
    always_comb begin
        err_sticky_d   = err_sticky_q || any_err;
        mismatch_cnt_d = mismatch_cnt_q;
        if (mismatch && (mismatch_cnt_q != '1)) begin
            mismatch_cnt_d = mismatch_cnt_q + 1'b1;
        end
        if (start) begin
            err_sticky_d   = 1'b0;
            mismatch_cnt_d = '0;
        end
    end

    // State, error pulses, sticky flag, counter and first-mismatch capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            err_mismatch_q  <= 1'b0;
            err_underflow_q <= 1'b0;
            err_overflow_q  <= 1'b0;
            err_sticky_q    <= 1'b0;
            mismatch_cnt_q  <= '0;
            cap_exp_q       <= '0;
            cap_act_q       <= '0;
        end else begin
            state_q         <= state_d;
            err_mismatch_q  <= mismatch;
            err_underflow_q <= underflow;
            err_overflow_q  <= overflow;
            err_sticky_q    <= err_sticky_d;
            mismatch_cnt_q  <= mismatch_cnt_d;
            if (start) begin
                cap_exp_q <= '0;
                cap_act_q <= '0;
            end else if (mismatch && !err_sticky_q) begin
                cap_exp_q <= cmp_ref;
                cap_act_q <= act_data;
            end
        end
    end

`ifdef HQM_ASSERTION_INORDER_CHK_REPORT_EN
    logic [DWIDTH-1:0] rpt_exp_q;
    logic [DWIDTH-1:0] rpt_act_q;

    // Remember the operands behind this cycle's error for the message one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_exp_q <= '0;
            rpt_act_q <= '0;
        end else begin
            rpt_exp_q <= overflow ? exp_data : cmp_ref;
            rpt_act_q <= act_data;
        end
    end

    // Simulation-only message on every error pulse
    always_ff @(posedge clk) begin
        if (err_mismatch_q) begin
            $error("hqm_assertion_inorder_chk: mismatch exp=%h act=%h", rpt_exp_q, rpt_act_q);
        end
        if (err_underflow_q) begin
            $error("hqm_assertion_inorder_chk: underflow exp=%h act=%h", rpt_exp_q, rpt_act_q);
        end
        if (err_overflow_q) begin
            $error("hqm_assertion_inorder_chk: overflow exp=%h act=%h", rpt_exp_q, rpt_act_q);
        end
    end
`else
    // reporting compiled out; port behaviour is unchanged
`endif

    assign occ           = occ_w;
    assign empty         = empty_w;
    assign full          = full_w;
    assign err_mismatch  = err_mismatch_q;
    assign err_underflow = err_underflow_q;
    assign err_overflow  = err_overflow_q;
    assign err_sticky    = err_sticky_q;
    assign mismatch_cnt  = mismatch_cnt_q;
    assign cap_exp       = cap_exp_q;
    assign cap_act       = cap_act_q;

endmodule

// File: tb/tb_hqm_assertion_inorder_chk.sv
// Bench for hqm_assertion_inorder_chk: directed scenarios followed by a
// randomized run, all checked against a queue-based reference model.
module tb_hqm_assertion_inorder_chk;
    import hqm_AW_pkg::*;

    localparam int DEPTH = 8;
    localparam int DW    = 16;
    localparam int AW    = 3;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          exp_v;
    logic [DW-1:0] exp_data;
    logic          act_v;
    logic [DW-1:0] act_data;
    logic [DW-1:0] cmp_mask;
    logic [AW:0]   occ;
    logic          empty;
    logic          full;
    logic          err_mismatch;
    logic          err_underflow;
    logic          err_overflow;
    logic          err_sticky;
    logic [15:0]   mismatch_cnt;
    logic [DW-1:0] cap_exp;
    logic [DW-1:0] cap_act;

    hqm_assertion_inorder_chk #(
        .DEPTH  (DEPTH),
        .DWIDTH (DW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .exp_v         (exp_v),
        .exp_data      (exp_data),
        .act_v         (act_v),
        .act_data      (act_data),
        .cmp_mask      (cmp_mask),
        .occ           (occ),
        .empty         (empty),
        .full          (full),
        .err_mismatch  (err_mismatch),
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow),
        .err_sticky    (err_sticky),
        .mismatch_cnt  (mismatch_cnt),
        .cap_exp       (cap_exp),
        .cap_act       (cap_act)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecs        = 0;
    int miscompares = 0;

    // reference model: the expected items still owed, plus checker status
    logic [DW-1:0] q[$];
    chk_state_t    m_state;
    bit            m_sticky;
    int            m_cnt;
    logic [DW-1:0] m_cap_exp;
    logic [DW-1:0] m_cap_act;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vecs++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, then check every output
    task automatic step(input logic ev, input logic [DW-1:0] ed,
                        input logic av, input logic [DW-1:0] ad,
                        input logic [DW-1:0] mk);
        bit            e_mm;
        bit            e_uf;
        bit            e_of;
        bit            cmp;
        bit            was_empty;
        bit            was_full;
        logic [DW-1:0] head;
        e_mm = 0; e_uf = 0; e_of = 0; cmp = 0; head = '0;
        exp_v    = ev;
        exp_data = ed;
        act_v    = av;
        act_data = ad;
        cmp_mask = mk;
        if (m_state == IDLE) begin
            if (enable) begin
                m_state   = RUN;
                m_sticky  = 0;
                m_cnt     = 0;
                m_cap_exp = '0;
                m_cap_act = '0;
            end
        end else if (!enable) begin
            m_state = IDLE;
            q.delete();
        end else begin
            was_empty = (q.size() == 0);
            was_full  = (q.size() == DEPTH);
            if (ev && av && was_empty) begin
                cmp  = 1;
                head = ed;
            end else begin
                if (av) begin
                    if (was_empty) e_uf = 1;
                    else begin
                        cmp  = 1;
                        head = q.pop_front();
                    end
                end
                if (ev) begin
                    if (was_full && !av) e_of = 1;
                    else q.push_back(ed);
                end
            end
            if (cmp && (((ad ^ head) & mk) != '0)) begin
                e_mm = 1;
                if (!m_sticky) begin
                    m_cap_exp = head;
                    m_cap_act = ad;
                end
                if (m_cnt < 65535) m_cnt++;
            end
            if (e_mm || e_uf || e_of) begin
                m_sticky = 1;
                m_state  = FAIL;
            end
        end
        @(posedge clk);
        #1;
        check("err_mismatch",  32'(err_mismatch),  32'(e_mm));
        check("err_underflow", 32'(err_underflow), 32'(e_uf));
        check("err_overflow",  32'(err_overflow),  32'(e_of));
        check("occ",           32'(occ),           32'(q.size()));
        check("empty",         32'(empty),         32'(q.size() == 0));
        check("full",          32'(full),          32'(q.size() == DEPTH));
        check("err_sticky",    32'(err_sticky),    32'(m_sticky));
        check("mismatch_cnt",  32'(mismatch_cnt),  32'(m_cnt));
        check("cap_exp",       32'(cap_exp),       32'(m_cap_exp));
        check("cap_act",       32'(cap_act),       32'(m_cap_act));
        check("state",         32'(dut.state_q),   32'(m_state));
    endtask

    task automatic restart();
        enable = 1'b0;
        step(0, '0, 0, '0, 16'hFFFF);
        enable = 1'b1;
        step(0, '0, 0, '0, 16'hFFFF);
    endtask

    initial begin
        logic [DW-1:0] rd_exp;
        logic [DW-1:0] rd_act;
        logic [DW-1:0] rd_mask;
        logic          rd_ev;
        logic          rd_av;

        rst_n    = 1'b0;
        enable   = 1'b0;
        exp_v    = 1'b0;
        exp_data = '0;
        act_v    = 1'b0;
        act_data = '0;
        cmp_mask = 16'hFFFF;
        m_state  = IDLE;
        m_sticky = 0;
        m_cnt    = 0;
        m_cap_exp = '0;
        m_cap_act = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_occ",          32'(occ),           32'd0);
        check("rst_empty",        32'(empty),         32'd1);
        check("rst_full",         32'(full),          32'd0);
        check("rst_err_mismatch", 32'(err_mismatch),  32'd0);
        check("rst_err_sticky",   32'(err_sticky),    32'd0);
        check("rst_mismatch_cnt", 32'(mismatch_cnt),  32'd0);
        check("rst_cap_exp",      32'(cap_exp),       32'd0);
        rst_n = 1'b1;

        // idle: items are ignored
        step(1, 16'h1234, 1, 16'h9999, 16'hFFFF);
        enable = 1'b1;
        step(0, '0, 0, '0, 16'hFFFF);

        // in-order pair
        step(1, 16'h1111, 0, '0, 16'hFFFF);
        step(1, 16'h2222, 0, '0, 16'hFFFF);
        step(0, '0, 1, 16'h1111, 16'hFFFF);
        step(0, '0, 1, 16'h2222, 16'hFFFF);
        check("pair_occ",   32'(occ),   32'd0);
        check("pair_empty", 32'(empty), 32'd1);

        // full-width mismatch
        step(1, 16'h00A5, 0, '0, 16'hFFFF);
        step(0, '0, 1, 16'h00A4, 16'hFFFF);
        check("mm_pulse",   32'(err_mismatch), 32'd1);
        check("mm_cnt",     32'(mismatch_cnt), 32'd1);
        check("mm_cap_exp", 32'(cap_exp),      32'h00A5);
        check("mm_cap_act", 32'(cap_act),      32'h00A4);
        check("mm_state",   32'(dut.state_q),  32'(FAIL));
        step(0, '0, 0, '0, 16'hFFFF);
        check("mm_pulse_once", 32'(err_mismatch), 32'd0);
        restart();

        // masked difference is not a mismatch
        step(1, 16'h00A5, 0, '0, 16'hFFFF);
        step(0, '0, 1, 16'h00A4, 16'hFFFE);
        check("mask_no_err", 32'(err_mismatch), 32'd0);

        // overflow on the ninth item, then drain in order
        for (int i = 0; i < 9; i++) step(1, 16'(16'h0100 + i), 0, '0, 16'hFFFF);
        check("ovf_occ", 32'(occ), 32'd8);
        for (int i = 0; i < 8; i++) step(0, '0, 1, 16'(16'h0100 + i), 16'hFFFF);
        restart();

        // underflow, then empty bypass
        step(0, '0, 1, 16'h0000, 16'hFFFF);
        check("udf_pulse", 32'(err_underflow), 32'd1);
        restart();
        step(1, 16'h3C3C, 1, 16'h3C3C, 16'hFFFF);
        check("bypass_occ", 32'(occ), 32'd0);

        // flush of pending items by a one-cycle disable
        for (int i = 0; i < 5; i++) step(1, 16'(16'h0200 + i), 0, '0, 16'hFFFF);
        restart();
        check("flush_occ",    32'(occ),        32'd0);
        check("flush_sticky", 32'(err_sticky), 32'd0);
        check("flush_udf",    32'(err_underflow), 32'd0);

        // streaming across pointer wrap
        step(1, 16'h5000, 0, '0, 16'hFFFF);
        for (int i = 0; i < 20; i++) step(1, 16'(16'h5001 + i), 1, 16'(16'h5000 + i), 16'hFFFF);
        step(0, '0, 1, 16'h5014, 16'hFFFF);
        check("wrap_sticky", 32'(err_sticky), 32'd0);

        // simultaneous push and pop while full
        for (int i = 0; i < 8; i++) step(1, 16'(16'h6000 + i), 0, '0, 16'hFFFF);
        for (int i = 0; i < 3; i++) step(1, 16'(16'h6008 + i), 1, 16'(16'h6000 + i), 16'hFFFF);
        check("full_both_occ", 32'(occ), 32'd8);
        for (int i = 3; i < 11; i++) step(0, '0, 1, 16'(16'h6000 + i), 16'hFFFF);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            enable  = ($urandom_range(0, 31) != 0);
            rd_ev   = ($urandom_range(0, 9) < 6);
            rd_av   = ($urandom_range(0, 9) < 5);
            rd_exp  = 16'($urandom);
            rd_act  = (q.size() > 0) ? q[0] : rd_exp;
            if ($urandom_range(0, 9) == 0) rd_act = rd_act ^ 16'(1 << $urandom_range(0, 15));
            rd_mask = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF;
            step(rd_ev, rd_exp, rd_av, rd_act, rd_mask);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
